univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 88 ++++++++
 tb/tb_univ_shift_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | univ_shift_reg : parameterised universal shift register, one-cycle ops  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero
);

  localparam logic [2:0] c_MODE_HOLD  = 3'b000;
  localparam logic [2:0] c_MODE_LOAD  = 3'b001;
  localparam logic [2:0] c_MODE_SHL   = 3'b010;
  localparam logic [2:0] c_MODE_SHR   = 3'b011;
  localparam logic [2:0] c_MODE_ROL   = 3'b100;
  localparam logic [2:0] c_MODE_ROR   = 3'b101;
  localparam logic [2:0] c_MODE_ASR   = 3'b110;
  localparam logic [2:0] c_MODE_CLEAR = 3'b111;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_asr;

  // A one-bit register has no neighbours: rotates and asr degenerate to hold.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign w_shl = sin_r;
      assign w_shr = sin_l;
      assign w_rol = q_q;
      assign w_ror = q_q;
      assign w_asr = q_q;
    end else begin : g_wide
      assign w_shl = {q_q[WIDTH-2:0], sin_r};
      assign w_shr = {sin_l, q_q[WIDTH-1:1]};
      assign w_rol = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      assign w_ror = {q_q[0], q_q[WIDTH-1:1]};
      assign w_asr = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        c_MODE_HOLD:  q_d = q_q;
        c_MODE_LOAD:  q_d = d;
        c_MODE_SHL:   q_d = w_shl;
        c_MODE_SHR:   q_d = w_shr;
        c_MODE_ROL:   q_d = w_rol;
        c_MODE_ROR:   q_d = w_ror;
        c_MODE_ASR:   q_d = w_asr;
        c_MODE_CLEAR: q_d = RESET_VAL;
        default:      q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign zero   = (q_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_univ_shift_reg : vector table, directed corners and random vs model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] q;
  logic       sout_l, sout_r, zero;
  logic       q1, sout_l1, sout_r1, zero1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .q(q),
    .sout_l(sout_l), .sout_r(sout_r), .zero(zero)
  );

  univ_shift_reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d[0]),
    .sin_r(sin_r), .sin_l(sin_l), .q(q1),
    .sout_l(sout_l1), .sout_r(sout_r1), .zero(zero1)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sr;
    logic       sl;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one operation, take one rising edge, settle 1 time unit past it.
  task automatic apply(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] dd, input logic sr, input logic sl);
    rst = r; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs8(input string nm, input logic [7:0] exp);
    chk({nm, ".q"}, q, exp);
    chk({nm, ".zero"}, zero, exp == 8'h00);
    chk({nm, ".sout_l"}, sout_l, exp >= 8'h80);
    chk({nm, ".sout_r"}, sout_r, exp % 2);
  endtask

  // Reference: register treated as an unsigned integer 0..255.
  function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic r,
      input logic e, input logic [2:0] m, input logic [7:0] dd,
      input logic sr, input logic sl);
    int v;
    int nv;
    v = cur;
    if (!r) return 8'h00;
    if (!e) return cur;
    case (m)
      3'd0:    nv = v;
      3'd1:    nv = dd;
      3'd2:    nv = (v * 2 + sr) % 256;
      3'd3:    nv = v / 2 + sl * 128;
      3'd4:    nv = (v * 2) % 256 + v / 128;
      3'd5:    nv = v / 2 + (v % 2) * 128;
      3'd6:    nv = v / 2 + ((v >= 128) ? 128 : 0);
      default: nv = 0;
    endcase
    return 8'(nv);
  endfunction

  initial begin
    logic [7:0] mq;
    logic       r, e, sr, sl;
    logic [2:0] m;
    logic [7:0] dd;

    rst = 1'b0; en = 1'b1; mode = 3'b001; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0;

    tbl.push_back('{1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 8'hFF});
    tbl.push_back('{1'b1, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 8'h81});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 8'h03});
    tbl.push_back('{1'b1, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1, 8'h81});
    tbl.push_back('{1'b1, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0, 8'hA5});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 8'h4B});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h96});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 8'h2D});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h5A});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 8'hB4});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h69});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 1'b1, 1'b1, 8'hD2});
    tbl.push_back('{1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'hA5});
    tbl.push_back('{1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'hD2});
    tbl.push_back('{1'b1, 1'b1, 3'd1, 8'h80, 1'b0, 1'b0, 8'h80});
    tbl.push_back('{1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hC0});
    tbl.push_back('{1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hE0});
    tbl.push_back('{1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hF0});
    tbl.push_back('{1'b1, 1'b1, 3'd1, 8'h40, 1'b0, 1'b0, 8'h40});
    tbl.push_back('{1'b1, 1'b1, 3'd6, 8'h00, 1'b1, 1'b1, 8'h20});
    tbl.push_back('{1'b1, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0, 8'h3C});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 1'b0, 3'(i), 8'hFF, 1'b1, 1'b1, 8'h3C});
    tbl.push_back('{1'b1, 1'b1, 3'd7, 8'h5A, 1'b1, 1'b1, 8'h00});

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].d, tbl[i].sr, tbl[i].sl);
      chk_outs8($sformatf("vec%0d", i), tbl[i].exp_q);
    end

    // Shifted-out bits visible before the edge.
    apply(1'b1, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
    chk("pre_shl.sout_l", sout_l, 1'b1);
    apply(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    chk("shl_discard.q", q, 8'h02);
    apply(1'b1, 1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
    chk("pre_shr.sout_r", sout_r, 1'b1);
    apply(1'b1, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    chk("shr_discard.q", q, 8'h00);

    // Reset aborts a rotate run; next op acts on the reset value.
    apply(1'b1, 1'b1, 3'd1, 8'hA5, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    chk_outs8("rst_mid_rol", 8'h00);
    apply(1'b1, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    chk("after_rst_shl.q", q, 8'h01);

    // A low pulse that does not cover an edge has no effect.
    apply(1'b1, 1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
    en = 1'b0;
    #2 rst = 1'b0;
    #2;
    chk("rst_glitch_async.q", q, 8'h5A);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_glitch_edge.q", q, 8'h5A);

    // Randomised run against the integer reference.
    apply(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    mq = 8'h00;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 15) != 0);
      e  = ($urandom_range(0, 4) != 0);
      m  = 3'($urandom_range(0, 7));
      dd = 8'($urandom);
      sr = 1'($urandom);
      sl = 1'($urandom);
      mq = ref_next(mq, r, e, m, dd, sr, sl);
      apply(r, e, m, dd, sr, sl);
      if (q !== mq || zero !== (mq == 8'h00) || sout_l !== mq[7] || sout_r !== mq[0])
        chk_outs8($sformatf("rand%0d", i), mq);
      else
        chk($sformatf("rand%0d.q", i), q, mq);
    end

    // One-bit build with RESET_VAL=1.
    apply(1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    chk("w1_reset.q", q1, 1'b1);
    apply(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
    chk("w1_shl.q", q1, 1'b0);
    apply(1'b1, 1'b1, 3'd4, 8'h00, 1'b1, 1'b1);
    chk("w1_rol0.q", q1, 1'b0);
    apply(1'b1, 1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
    chk("w1_load.q", q1, 1'b1);
    apply(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    chk("w1_rol1.q", q1, 1'b1);
    apply(1'b1, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    chk("w1_ror.q", q1, 1'b1);
    apply(1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
    chk("w1_asr.q", q1, 1'b1);
    chk("w1_sout_l", sout_l1, 1'b1);
    chk("w1_sout_r", sout_r1, 1'b1);
    apply(1'b1, 1'b1, 3'd3, 8'h00, 1'b1, 1'b0);
    chk("w1_shr0.q", q1, 1'b0);
    chk("w1_zero", zero1, 1'b1);
    apply(1'b1, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
    chk("w1_shr1.q", q1, 1'b1);
    apply(1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
    chk("w1_clear.q", q1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
